// File: rtl/instr_fetch_unit_if.sv
// Bus between the multicycle controller side and instr_fetch_unit: program-load
// port, PC/IR write strobes, and the decoded instruction fields coming back.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 6
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_data;
  logic              ir_write;
  logic              pc_write;
  logic              pc_write_cond;
  logic              zero;
  logic [1:0]        pc_src;

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic [31:0]       pc;
  logic [31:0]       ir;
  logic              ir_valid;
  logic [15:0]       fetch_count;
  logic              fault;

  modport master (
    output prog_we, prog_addr, prog_data, ir_write, pc_write, pc_write_cond, zero, pc_src,
    input  op, funct, rs, rt, rd, imm, pc, ir, ir_valid, fetch_count, fault
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, ir_write, pc_write, pc_write_cond, zero, pc_src,
    output op, funct, rs, rt, rd, imm, pc, ir, ir_valid, fetch_count, fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-side responder for the multicycle controller: PC, IR and a small
// instruction memory, driven by the controller's PC/IR write strobes.
module instr_fetch_unit #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_HOLD   = 2'b11
  } pc_src_e;

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic        fault_q, fault_d;

  logic              in_range;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       branch_off;
  logic              pc_en;
  pc_src_e           pc_src;

  assign in_range   = (pc_q[31:ADDR_W+2] == '0);
  assign word_idx   = pc_q[ADDR_W+1:2];
  assign branch_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign pc_en      = bus.pc_write | (bus.pc_write_cond & bus.zero);
  assign pc_src     = pc_src_e'(bus.pc_src);

  // NOTE: memory has no reset; program contents must survive a controller reset,
  // and leaving reset off lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
  end

  // Next state is computed from the pre-edge PC/IR, so a fetch and a PC update on
  // the same edge see the old PC, and a same-edge program write is read as old data.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    pc_d          = pc_q;
    ir_d          = ir_q;
    ir_valid_d    = ir_valid_q;
    fetch_count_d = fetch_count_q;
    fault_d       = fault_q;

    if (bus.ir_write) begin
      ir_valid_d    = 1'b1;
      fetch_count_d = fetch_count_q + 16'd1;
      if (in_range) begin
        ir_d = mem[word_idx];
      end else begin
        ir_d    = 32'h0000_0000;
        fault_d = 1'b1;
      end
    end

    if (pc_en) begin
      unique case (pc_src)
        PC_SEQ:    pc_d = pc_q + 32'd4;
        PC_BRANCH: pc_d = pc_q + branch_off;
        PC_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
        PC_HOLD:   pc_d = pc_q;
        default:   pc_d = pc_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      ir_q          <= 32'h0000_0000;
      ir_valid_q    <= 1'b0;
      fetch_count_q <= 16'd0;
      fault_q       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      ir_valid_q    <= ir_valid_d;
      fetch_count_q <= fetch_count_d;
      fault_q       <= fault_d;
    end
  end

  assign bus.op          = ir_q[31:26];
  assign bus.rs          = ir_q[25:21];
  assign bus.rt          = ir_q[20:16];
  assign bus.rd          = ir_q[15:11];
  assign bus.funct       = ir_q[5:0];
  assign bus.imm         = ir_q[15:0];
  assign bus.pc          = pc_q;
  assign bus.ir          = ir_q;
  assign bus.ir_valid    = ir_valid_q;
  assign bus.fetch_count = fetch_count_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed controller sequences push
// hand-computed expectations; a negedge monitor pops and compares them.
module tb_instr_fetch_unit;

  typedef enum {S_PC, S_IR, S_OP, S_FUNCT, S_RS, S_RT, S_RD, S_IMM,
                S_VALID, S_COUNT, S_FAULT} sel_e;

  typedef struct {
    sel_e        sel;
    logic [31:0] exp;
    string       tag;
  } sb_entry_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  sb_entry_t sb[$];

  instr_fetch_unit_if #(.ADDR_W(6)) bus ();

  instr_fetch_unit #(.ADDR_W(6), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] actual(input sel_e s);
    case (s)
      S_PC:    return bus.pc;
      S_IR:    return bus.ir;
      S_OP:    return {26'd0, bus.op};
      S_FUNCT: return {26'd0, bus.funct};
      S_RS:    return {27'd0, bus.rs};
      S_RT:    return {27'd0, bus.rt};
      S_RD:    return {27'd0, bus.rd};
      S_IMM:   return {16'd0, bus.imm};
      S_VALID: return {31'd0, bus.ir_valid};
      S_COUNT: return {16'd0, bus.fetch_count};
      S_FAULT: return {31'd0, bus.fault};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: drains every expectation queued since the last edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        sb_entry_t e;
        e = sb.pop_front();
        check(e.tag, actual(e.sel), e.exp);
      end
    end
  end

  task automatic expect_val(input sel_e s, input logic [31:0] v, input string tag);
    sb.push_back('{sel: s, exp: v, tag: tag});
  endtask

  task automatic expect_fetch(input logic [31:0] ir_e, input logic [31:0] pc_e,
                              input logic [15:0] cnt_e, input string tag);
    expect_val(S_IR, ir_e, {tag, ".ir"});
    expect_val(S_PC, pc_e, {tag, ".pc"});
    expect_val(S_COUNT, {16'd0, cnt_e}, {tag, ".fetch_count"});
    expect_val(S_VALID, 32'd1, {tag, ".ir_valid"});
  endtask

  task automatic expect_reset(input string tag);
    expect_val(S_PC, 32'h0, {tag, ".pc"});
    expect_val(S_IR, 32'h0, {tag, ".ir"});
    expect_val(S_VALID, 32'd0, {tag, ".ir_valid"});
    expect_val(S_COUNT, 32'd0, {tag, ".fetch_count"});
    expect_val(S_FAULT, 32'd0, {tag, ".fault"});
  endtask

  task automatic clear_inputs();
    reset             = 1'b0;
    bus.prog_we       = 1'b0;
    bus.prog_addr     = '0;
    bus.prog_data     = '0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.zero          = 1'b0;
    bus.pc_src        = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic load(input logic [5:0] addr, input logic [31:0] data);
    bus.prog_we = 1'b1; bus.prog_addr = addr; bus.prog_data = data;
    step();
  endtask

  task automatic fetch();
    bus.ir_write = 1'b1; bus.pc_write = 1'b1; bus.pc_src = 2'b00;
    step();
  endtask

  task automatic pc_wr(input logic [1:0] src);
    bus.pc_write = 1'b1; bus.pc_src = src;
    step();
  endtask

  task automatic pc_cond(input logic [1:0] src, input logic z);
    bus.pc_write_cond = 1'b1; bus.zero = z; bus.pc_src = src;
    step();
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    reset = 1'b1;
    step();
    expect_reset("reset");

    load(6'd0, 32'h8C22_0004);
    load(6'd1, 32'h1000_FFFF);
    load(6'd2, 32'h0800_0010);
    load(6'd3, 32'h0043_2820);
    load(6'd16, 32'h0800_0040);
    expect_val(S_PC, 32'h0, "idle_after_load.pc");
    expect_val(S_VALID, 32'd0, "idle_after_load.ir_valid");

    // First fetch: lw r2, 4(r1)
    fetch();
    expect_fetch(32'h8C22_0004, 32'h4, 16'd1, "fetch0");
    expect_val(S_OP, 32'h23, "fetch0.op");
    expect_val(S_RS, 32'd1, "fetch0.rs");
    expect_val(S_RT, 32'd2, "fetch0.rt");
    expect_val(S_IMM, 32'd4, "fetch0.imm");

    // Branch with offset -1 words, taken and not taken
    fetch();
    expect_fetch(32'h1000_FFFF, 32'h8, 16'd2, "fetch_br");
    pc_cond(2'b01, 1'b1);
    expect_val(S_PC, 32'h4, "branch_taken.pc");
    fetch();
    expect_fetch(32'h1000_FFFF, 32'h8, 16'd3, "fetch_br2");
    pc_cond(2'b01, 1'b0);
    expect_val(S_PC, 32'h8, "branch_not_taken.pc");

    // Walk PC down through zero to the top of the address space and wrap
    pc_wr(2'b01);
    expect_val(S_PC, 32'h4, "branch_back1.pc");
    pc_wr(2'b01);
    expect_val(S_PC, 32'h0, "branch_back2.pc");
    pc_wr(2'b01);
    expect_val(S_PC, 32'hFFFF_FFFC, "branch_underflow.pc");
    pc_wr(2'b00);
    expect_val(S_PC, 32'h0, "seq_wrap.pc");
    pc_wr(2'b11);
    expect_val(S_PC, 32'h0, "hold.pc");

    // Jump
    fetch();
    fetch();
    fetch();
    expect_fetch(32'h0800_0010, 32'hC, 16'd6, "fetch_j");
    pc_wr(2'b10);
    expect_val(S_PC, 32'h40, "jump.pc");

    // Jump out of memory, then fetch there
    fetch();
    expect_fetch(32'h0800_0040, 32'h44, 16'd7, "fetch_j2");
    pc_wr(2'b10);
    expect_val(S_PC, 32'h100, "jump_oor.pc");
    fetch();
    expect_fetch(32'h0, 32'h104, 16'd8, "fetch_oor");
    expect_val(S_OP, 32'h0, "fetch_oor.op");
    expect_val(S_FAULT, 32'd1, "fetch_oor.fault");
    pc_wr(2'b10);
    expect_val(S_PC, 32'h0, "jump_nop.pc");
    fetch();
    expect_fetch(32'h8C22_0004, 32'h4, 16'd9, "fetch_after_fault");
    expect_val(S_FAULT, 32'd1, "fault_sticky");

    // All strobes low
    step();
    step();
    expect_fetch(32'h8C22_0004, 32'h4, 16'd9, "idle_hold");
    expect_val(S_FAULT, 32'd1, "idle_hold.fault");

    reset = 1'b1;
    step();
    expect_reset("reset2");

    // Program write and fetch to the same word on the same edge
    bus.prog_we = 1'b1; bus.prog_addr = 6'd0; bus.prog_data = 32'hAC00_0000;
    fetch();
    expect_fetch(32'h8C22_0004, 32'h4, 16'd1, "rbw");

    bus.pc_write_cond = 1'b1; bus.zero = 1'b0;
    pc_wr(2'b00);
    expect_val(S_PC, 32'h8, "both_strobes.pc");

    fetch();
    expect_fetch(32'h0800_0010, 32'hC, 16'd2, "fetch_8");
    fetch();
    expect_fetch(32'h0043_2820, 32'h10, 16'd3, "fetch_rtype");
    expect_val(S_RS, 32'd2, "fetch_rtype.rs");
    expect_val(S_RT, 32'd3, "fetch_rtype.rt");
    expect_val(S_RD, 32'd5, "fetch_rtype.rd");
    expect_val(S_FUNCT, 32'h20, "fetch_rtype.funct");

    // Reset wins over a simultaneous fetch cycle
    reset = 1'b1; bus.ir_write = 1'b1; bus.pc_write = 1'b1;
    step();
    expect_reset("reset_over_fetch");

    fetch();
    expect_fetch(32'hAC00_0000, 32'h4, 16'd1, "refetch");
    expect_val(S_OP, 32'h2B, "refetch.op");

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-side responder for the multicycle controller (`cont_logic`). It holds the PC, the instruction register and a small instruction memory. It obeys the controller's PC and IR write strobes and returns the opcode and instruction fields that drive the controller's next-state logic. It sits between instruction memory and `cont_logic`, and replaces hand-driven `op` stimulus in controller benches.

## Interface
- `ADDR_W`, 6: instruction-memory word-address width; depth is 2^ADDR_W words.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `prog_we` in 1: memory load strobe.
- `prog_addr` in ADDR_W: word address for a load.
- `prog_data` in 32: word to load.
- `ir_write` in 1: latch the instruction at the current PC into IR.
- `pc_write` in 1: unconditional PC update.
- `pc_write_cond` in 1: PC update if `zero`.
- `zero` in 1: ALU zero flag from the datapath.
- `pc_src` in 2: 00 sequential (PC+4), 01 branch target, 10 jump target, 11 hold.
- `op` out 6: IR[31:26], to the controller.
- `funct` out 6: IR[5:0].
- `rs`, `rt`, `rd` out 5 each: IR[25:21], IR[20:16], IR[15:11].
- `imm` out 16: IR[15:0].
- `pc` out 32: current PC.
- `ir` out 32: instruction register.
- `ir_valid` out 1: IR has been loaded since the last reset.
- `fetch_count` out 16: number of `ir_write` events since reset.
- `fault` out 1: sticky; a fetch targeted a PC outside memory.

## Operation
- Memory: 2^ADDR_W x 32, asynchronous read at word index `pc[ADDR_W+1:2]`, synchronous write when `prog_we` is high. Reset does not clear memory.
- In-range test: `pc[31:ADDR_W+2] == 0`.
- On `ir_write`:
  - In range: IR <= mem[word index].
  - Out of range: IR <= 32'h0 (NOP, `op` = 000000) and `fault` <= 1.
  - In both cases `ir_valid` <= 1 and `fetch_count` <= `fetch_count` + 1, wrapping at 16'hFFFF -> 0.
- PC update enable: `pc_write | (pc_write_cond & zero)`. `pc_write` dominates; `pc_write_cond` alone with `zero`=0 leaves PC unchanged.
- Next-PC sources, using the pre-edge PC and IR:
  - 00: PC + 4, mod 2^32 (32'hFFFF_FFFC -> 0).
  - 01: PC + (sign-extended imm << 2), mod 2^32. PC here is already PC+4 from fetch, per the multicycle convention.
  - 10: {PC[31:28], IR[25:0], 2'b00}.
  - 11: PC unchanged.
- Field outputs (`op`, `funct`, `rs`, `rt`, `rd`, `imm`) are combinational slices of IR.
- Reset: PC <= RESET_PC, IR <= 0, `ir_valid` <= 0, `fetch_count` <= 0, `fault` <= 0. Reset overrides every strobe in the same cycle. Reset between a fetch and the following PC write abandons that instruction; no partial update survives.

## Timing
- Fetch cycle as driven by the controller: `ir_write`=1, `pc_write`=1, `pc_src`=00. On that edge IR takes mem[old PC] and PC becomes old PC + 4.
- Latency: `op` is valid the cycle after the `ir_write` edge and stays valid until the next `ir_write`.
- Read-before-write: if `prog_we` and `ir_write` hit the same word on the same edge, IR gets the old contents.
- Branch or jump resolved at edge k: the next fetch (edge k+1 or later) reads the new PC.
- With all strobes low, every register holds indefinitely.

## Test plan
- Reset, then load mem[0]=32'h8C22_0004 and pulse the fetch cycle: `op`=6'b100011, `rs`=1, `rt`=2, `imm`=4, `pc`=4, `ir_valid`=1, `fetch_count`=1.
- Branch taken: mem[1]=32'h1000_FFFF, fetch (PC 4 -> 8), then `pc_write_cond`=1, `zero`=1, `pc_src`=01: `pc`=4. Same sequence with `zero`=0: `pc` stays 8.
- Jump: mem[2]=32'h0800_0010, fetch from PC 8, then `pc_write`=1, `pc_src`=10: `pc`=32'h40.
- Out-of-range fetch: jump to 32'h100 with ADDR_W=6, then fetch: `ir`=0, `op`=0, `fault`=1. `fault` remains 1 through later in-range fetches until reset.
- Simultaneous strobes:
  - `prog_we` to word 0 (new 32'hAC00_0000) together with `ir_write` at PC 0: IR=old word.
  - `pc_write` and `pc_write_cond` with `zero`=0: PC updates.
- Mid-run reset after three fetches: the next cycle shows `pc`=RESET_PC, `ir`=0, `ir_valid`=0, `fetch_count`=0, and memory contents are intact on a re-fetch.
